of_flow_table: RTL

OpenFlow 1.0 flow-match engine that answers the per-packet lookup requests issued by each port's forwarder. It compares the 243-bit match tuple against a small table of wildcard entries and returns the forwarding-port bitmap of the highest-priority hit, or a programmable default on a miss. It sits between the forwarders and the management/CPU interface, which writes entries and reads per-entry hit statistics. One instance serves one forwarder.

---
 rtl/of_flow_table.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/of_flow_table.sv
// OpenFlow 1.0 wildcard flow table: 3-stage lookup pipeline (capture, compare, priority
// select), entry write port and per-entry hit / miss statistics counters.
module of_flow_table #(
    parameter int NPORT = 4,
    parameter int AW    = 3,
    parameter int KW    = 243
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             of_lookup_req,
    input  logic [KW-1:0]    of_lookup_data,
    output logic             of_lookup_ack,
    output logic [NPORT-1:0] of_lookup_fwd_port,
    input  logic [NPORT-1:0] default_fwd_port,
    input  logic             tbl_wr_en,
    input  logic [AW-1:0]    tbl_wr_addr,
    input  logic             tbl_wr_valid,
    input  logic [KW-1:0]    tbl_wr_key,
    input  logic [KW-1:0]    tbl_wr_mask,
    input  logic [NPORT-1:0] tbl_wr_action,
    input  logic             stat_rd_en,
    input  logic [AW:0]      stat_addr,
    output logic [31:0]      stat_dout
);
    localparam int NENTRY = 1 << AW;
    localparam logic [AW:0] MISS_ADDR = (AW+1)'(NENTRY);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Lowest set index wins; index 0 has the highest priority.
    function automatic logic [AW-1:0] prio_enc(input logic [NENTRY-1:0] hits);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = NENTRY - 1; i >= 0; i--) begin
            if (hits[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    logic [NENTRY-1:0] valid_q;
    logic [KW-1:0]     key_q    [NENTRY];
    logic [KW-1:0]     mask_q   [NENTRY];
    logic [NPORT-1:0]  action_q [NENTRY];

    logic              vld_p1_q;
    logic [KW-1:0]     data_p1_q;
    logic              vld_p2_q;
    logic [NENTRY-1:0] hit_p2_d;
    logic [NENTRY-1:0] hit_p2_q;
    logic [NPORT-1:0]  act_p2_q [NENTRY];
    logic [AW-1:0]     win_d;
    logic              miss_d;
    logic [NPORT-1:0]  fwd_d;
    logic              ack_q;
    logic [NPORT-1:0]  fwd_q;
    logic [AW-1:0]     win_q;
    logic              miss_q;

    logic [31:0]       hit_cnt_q [NENTRY];
    logic [31:0]       miss_cnt_q;
    logic [31:0]       stat_d;
    logic [31:0]       stat_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            valid_q <= '0;
        end else if (tbl_wr_en) begin
            valid_q[tbl_wr_addr] <= tbl_wr_valid;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (tbl_wr_en) begin
            key_q[tbl_wr_addr]    <= tbl_wr_key;
            mask_q[tbl_wr_addr]   <= tbl_wr_mask;
            action_q[tbl_wr_addr] <= tbl_wr_action;
        end
    end

    // S1: capture request
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= of_lookup_req;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (of_lookup_req) begin
            data_p1_q <= of_lookup_data;
        end
    end

    // S2: compare against every entry in parallel
    always_comb begin
        hit_p2_d = '0;
        for (int i = 0; i < NENTRY; i++) begin
            hit_p2_d[i] = valid_q[i] && (((data_p1_q ^ key_q[i]) & mask_q[i]) == '0);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            vld_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
        end
    end

    // Actions are snapshotted with the hit vector so a write landing between S2 and
    // S3 cannot pair an old match with a new action.
    always_ff @(posedge sys_clk) begin
        if (vld_p1_q) begin
            hit_p2_q <= hit_p2_d;
            for (int i = 0; i < NENTRY; i++) begin
                act_p2_q[i] <= action_q[i];
            end
        end
    end

    // S3: priority select and result register
    always_comb begin
        win_d  = prio_enc(hit_p2_q);
        miss_d = ~|hit_p2_q;
        fwd_d  = miss_d ? default_fwd_port : act_p2_q[win_d];
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ack_q  <= 1'b0;
            fwd_q  <= '0;
            win_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            ack_q <= vld_p2_q;
            if (vld_p2_q) begin
                fwd_q  <= fwd_d;
                win_q  <= win_d;
                miss_q <= miss_d;
            end
        end
    end

    // A table write clears its counter and takes precedence over a same-cycle hit.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NENTRY; i++) begin
                hit_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NENTRY; i++) begin
                if (tbl_wr_en && tbl_wr_addr == AW'(i)) begin
                    hit_cnt_q[i] <= '0;
                end else if (ack_q && !miss_q && win_q == AW'(i)) begin
                    hit_cnt_q[i] <= sat_inc(hit_cnt_q[i]);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            miss_cnt_q <= '0;
        end else if (ack_q && miss_q) begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    always_comb begin
        stat_d = '0;
        if (stat_addr < MISS_ADDR) begin
            stat_d = hit_cnt_q[stat_addr[AW-1:0]];
        end else if (stat_addr == MISS_ADDR) begin
            stat_d = miss_cnt_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            stat_q <= '0;
        end else if (stat_rd_en) begin
            stat_q <= stat_d;
        end
    end

    assign of_lookup_ack      = ack_q;
    assign of_lookup_fwd_port = fwd_q;
    assign stat_dout          = stat_q;

endmodule
